imem_loader: RTL and testbench

//   Writer side of the instruction memory: loads a program into the instruction RAM

---
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the program loader.
// The master modport is the loader; the slave modport is the byte source plus the RAM.
interface imem_loader_if #(
    parameter int ADDR_W = 4
);
    // Stream handshake: a byte moves on a rising edge where in_valid and in_ready
    // are both high; in_data must be stable while in_valid is high.
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a program into the instruction RAM from a length-prefixed byte stream,
// packing words MSB byte first and holding the CPU until the image is complete.
module imem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   len_q;
    logic [1:0]        byte_cnt;
    logic [23:0]       shreg;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              accept;
    logic              len_zero;
    logic              len_over;

    assign accept   = bus.in_valid & bus.in_ready;
    assign len_zero = (bus.in_data == 8'd0);
    assign len_over = int'({24'd0, bus.in_data}) > DEPTH;
    // One extra counter bit lets N == 2**ADDR_W terminate without wrapping to 0.
    assign cnt_inc  = word_cnt + (ADDR_W+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = LEN;
            LEN: begin
                if (bus.in_valid) begin
                    if (len_zero)      state_d = DONE;
                    else if (len_over) state_d = ERR;
                    else               state_d = DATA;
                end
            end
            DATA:  if (bus.in_valid && byte_cnt == 2'd3) state_d = WRITE;
            WRITE: state_d = (cnt_inc == len_q) ? DONE : DATA;
            DONE:  if (start) state_d = LEN;
            ERR:   if (start) state_d = LEN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                LEN: begin
                    if (accept && !len_zero && !len_over) begin
                        len_q <= (ADDR_W+1)'(bus.in_data);
                    end
                end
                DATA: begin
                    if (accept) begin
                        shreg    <= {shreg[15:0], bus.in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        // Load the write bus as the word completes so it is valid
                        // throughout WRITE and holds afterwards.
                        if (byte_cnt == 2'd3) begin
                            wdata_q <= {shreg, bus.in_data};
                            waddr_q <= word_cnt[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: word_cnt <= cnt_inc;
                default: ;
            endcase
        end
    end

    assign bus.in_ready = (state_q == LEN) || (state_q == DATA);
    assign bus.we       = (state_q == WRITE);
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign cpu_hold     = (state_q != DONE);
    assign done         = (state_q == DONE);
    assign err          = (state_q == ERR);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, empty and oversized images, full depth,
// stalled streams and reset in the middle of a load.
module tb_imem_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [2:0] dbg_state;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_viol = 0;

    // Scoreboard: expected writes and writes observed on the RAM bus
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wr_data_q.push_back(bus.wdata);
            wr_addr_q.push_back(bus.waddr);
            if (bus.in_ready !== 1'b0) ready_viol++;
        end
    end

    // Driver tasks: all start and end just after a falling edge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte_timeout: byte %02h not accepted within 100 cycles", b);
        end
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1 || err === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        exp_addr_q.delete();
        wr_data_q.delete();
        wr_addr_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        #12;
        checks++;
        if ({cpu_hold, done, err, bus.we, bus.in_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: hold/done/err/we/ready=%b expected 10000",
                     {cpu_hold, done, err, bus.we, bus.in_ready});
        end
        checks++;
        if (bus.waddr !== '0 || bus.wdata !== 32'h0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_bus: waddr=%0h wdata=%08h state=%0d expected 0 0 0",
                     bus.waddr, bus.wdata, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle_hold: hold=%b state=%0d expected 1 0", cpu_hold, dbg_state);
        end
    endtask

    task automatic test_basic_load();
        bit ok;
        logic [31:0] d;
        logic [ADDR_W-1:0] a;
        clear_sb();
        exp_q.push_back(32'h11223344); exp_addr_q.push_back(4'd0);
        exp_q.push_back(32'hAABBCCDD); exp_addr_q.push_back(4'd1);
        pulse_start();
        checks++;
        if (cpu_hold !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_len_state: hold=%b ready=%b expected 1 1", cpu_hold, bus.in_ready);
        end
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        pulse_start();
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        checks++;
        if (bus.we !== 1'b1 || bus.waddr !== 4'd0 || bus.wdata !== 32'h11223344) begin
            errors++;
            $display("FAIL basic_latency: we=%b waddr=%0h wdata=%08h expected 1 0 11223344",
                     bus.we, bus.waddr, bus.wdata);
        end
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        wait_end(ok);
        checks++;
        if (!ok || done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b err=%b hold=%b expected 1 0 0", done, err, cpu_hold);
        end
        checks++;
        if (wr_data_q.size() != 2) begin
            errors++;
            $display("FAIL basic_count: writes=%0d expected 2", wr_data_q.size());
        end
        while (exp_q.size() > 0 && wr_data_q.size() > 0) begin
            d = wr_data_q.pop_front();
            a = wr_addr_q.pop_front();
            checks++;
            if (d !== exp_q[0] || a !== exp_addr_q[0]) begin
                errors++;
                $display("FAIL basic_write: addr=%0h data=%08h expected addr=%0h data=%08h",
                         a, d, exp_addr_q[0], exp_q[0]);
            end
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
        end
    endtask

    task automatic test_zero_count();
        bit ok;
        clear_sb();
        pulse_start();
        checks++;
        if (done !== 1'b0 || dbg_state !== 3'd1) begin
            errors++;
            $display("FAIL zero_restart: done=%b state=%0d expected 0 1", done, dbg_state);
        end
        send_byte(8'h00, 0);
        wait_end(ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || done !== 1'b1 || err !== 1'b0 || wr_data_q.size() != 0) begin
            errors++;
            $display("FAIL zero_count: done=%b err=%b writes=%0d expected 1 0 0",
                     done, err, wr_data_q.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_sb();
        pulse_start();
        send_byte(8'h11, 0);
        wait_end(ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || wr_data_q.size() != 0) begin
            errors++;
            $display("FAIL overflow: err=%b done=%b hold=%b writes=%0d expected 1 0 1 0",
                     err, done, cpu_hold, wr_data_q.size());
        end
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_retry_clear: err=%b expected 0", err);
        end
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        wait_end(ok);
        checks++;
        if (!ok || done !== 1'b1 || cpu_hold !== 1'b0 || wr_data_q.size() != 1) begin
            errors++;
            $display("FAIL retry_done: done=%b hold=%b writes=%0d expected 1 0 1",
                     done, cpu_hold, wr_data_q.size());
        end else begin
            checks++;
            if (wr_data_q[0] !== 32'hDEADBEEF || wr_addr_q[0] !== 4'd0) begin
                errors++;
                $display("FAIL retry_write: addr=%0h data=%08h expected 0 deadbeef",
                         wr_addr_q[0], wr_data_q[0]);
            end
        end
    endtask

    task automatic test_full_depth();
        bit ok;
        logic [31:0] d;
        logic [ADDR_W-1:0] a;
        clear_sb();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
            exp_addr_q.push_back(ADDR_W'(i));
        end
        pulse_start();
        send_byte(8'h10, 0);
        for (int i = 0; i < 4*DEPTH; i++) send_byte(8'(i), 0);
        wait_end(ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || done !== 1'b1 || err !== 1'b0 || wr_data_q.size() != DEPTH) begin
            errors++;
            $display("FAIL full_done: done=%b err=%b writes=%0d expected 1 0 16",
                     done, err, wr_data_q.size());
        end
        while (exp_q.size() > 0 && wr_data_q.size() > 0) begin
            d = wr_data_q.pop_front();
            a = wr_addr_q.pop_front();
            checks++;
            if (d !== exp_q[0] || a !== exp_addr_q[0]) begin
                errors++;
                $display("FAIL full_write: addr=%0h data=%08h expected addr=%0h data=%08h",
                         a, d, exp_addr_q[0], exp_q[0]);
            end
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
        end
    endtask

    task automatic test_stalls();
        bit ok;
        logic [31:0] d;
        logic [ADDR_W-1:0] a;
        logic [7:0] bytes [9] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        int gaps [9] = '{1, 0, 2, 1, 3, 0, 2, 1, 3};
        clear_sb();
        ready_viol = 0;
        exp_q.push_back(32'h11223344); exp_addr_q.push_back(4'd0);
        exp_q.push_back(32'hAABBCCDD); exp_addr_q.push_back(4'd1);
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(bytes[i], gaps[i]);
        wait_end(ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || done !== 1'b1 || wr_data_q.size() != 2 || ready_viol != 0) begin
            errors++;
            $display("FAIL stall_done: done=%b writes=%0d ready_in_write=%0d expected 1 2 0",
                     done, wr_data_q.size(), ready_viol);
        end
        while (exp_q.size() > 0 && wr_data_q.size() > 0) begin
            d = wr_data_q.pop_front();
            a = wr_addr_q.pop_front();
            checks++;
            if (d !== exp_q[0] || a !== exp_addr_q[0]) begin
                errors++;
                $display("FAIL stall_write: addr=%0h data=%08h expected addr=%0h data=%08h",
                         a, d, exp_addr_q[0], exp_q[0]);
            end
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        logic [7:0] bytes [7] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        clear_sb();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(bytes[i], 0);
        rst = 1'b1;
        #1;
        checks++;
        if ({cpu_hold, done, err, bus.we, bus.in_ready} !== 5'b10000 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL midreset_flags: hold/done/err/we/ready=%b state=%0d expected 10000 0",
                     {cpu_hold, done, err, bus.we, bus.in_ready}, dbg_state);
        end
        checks++;
        if (bus.waddr !== '0 || bus.wdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_bus: waddr=%0h wdata=%08h expected 0 0", bus.waddr, bus.wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_sb();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        wait_end(ok);
        checks++;
        if (!ok || done !== 1'b1 || wr_data_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_reload: done=%b writes=%0d expected 1 1", done, wr_data_q.size());
        end else begin
            checks++;
            if (wr_data_q[0] !== 32'h01020304 || wr_addr_q[0] !== 4'd0) begin
                errors++;
                $display("FAIL midreset_write: addr=%0h data=%08h expected 0 01020304",
                         wr_addr_q[0], wr_data_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_zero_count();
        test_overflow();
        test_full_depth();
        test_stalls();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
